// File: rtl/sm83_regfile.sv
// SM83 architectural register file: A, F, B, C, D, E, H, L, SP, PC with 8-bit
// and 16-bit pair access, masked flag writes, pointer steps and a PC shadow stack.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   rd_sel / rd_data           NUM_RD packed 8-bit read ports (0 B .. 5 L, 6 A, 7 F)
//   wr8_en/_sel/_data          single-byte write
//   wr16_en/_sel/_data         pair write (0 BC, 1 DE, 2 HL, 3 SP, 4 AF, 5 PC)
//   flag_we / flag_in          per-flag write, {Z,N,H,C}
//   pc_inc, sp_inc/dec, hl_inc/dec  pointer steps by one
//   sh_push, sh_pop            PC shadow stack operations
//   pc, sp, hl, flags          registered architectural state
//   sh_full, sh_empty, sh_err  stack status; sh_err is sticky until reset
module sm83_regfile #(
    parameter int unsigned          DATA_W       = 8,
    parameter int unsigned          NUM_RD       = 2,
    parameter bit                   BYPASS       = 1'b0,
    parameter int unsigned          SHADOW_DEPTH = 2,
    parameter logic [2*DATA_W-1:0]  PC_RESET     = '0,
    parameter logic [2*DATA_W-1:0]  SP_RESET     = 16'hFFFE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*3-1:0]        rd_sel,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       wr8_en,
    input  logic [2:0]                 wr8_sel,
    input  logic [DATA_W-1:0]          wr8_data,
    input  logic                       wr16_en,
    input  logic [2:0]                 wr16_sel,
    input  logic [2*DATA_W-1:0]        wr16_data,
    input  logic [3:0]                 flag_we,
    input  logic [3:0]                 flag_in,
    input  logic                       pc_inc,
    input  logic                       sp_inc,
    input  logic                       sp_dec,
    input  logic                       hl_inc,
    input  logic                       hl_dec,
    input  logic                       sh_push,
    input  logic                       sh_pop,
    output logic [2*DATA_W-1:0]        pc,
    output logic [2*DATA_W-1:0]        sp,
    output logic [2*DATA_W-1:0]        hl,
    output logic [3:0]                 flags,
    output logic                       sh_full,
    output logic                       sh_empty,
    output logic                       sh_err
);

    localparam int unsigned PW     = 2 * DATA_W;
    localparam int unsigned DepthW = $clog2(SHADOW_DEPTH + 1);
    localparam int unsigned IdxW   = (SHADOW_DEPTH > 1) ? $clog2(SHADOW_DEPTH) : 1;

    localparam logic [DepthW-1:0] DepthMax = DepthW'(SHADOW_DEPTH);
    localparam logic [PW-1:0]     PairOne  = PW'(1);
    // F keeps only its top four bits
    localparam logic [DATA_W-1:0] FMask    = ~(DATA_W'((1 << (DATA_W - 4)) - 1));

    localparam logic [2:0] RegB = 3'd0, RegC = 3'd1, RegD = 3'd2, RegE = 3'd3;
    localparam logic [2:0] RegH = 3'd4, RegL = 3'd5, RegA = 3'd6, RegF = 3'd7;

    localparam logic [2:0] PairBc = 3'd0, PairDe = 3'd1, PairHl = 3'd2;
    localparam logic [2:0] PairSp = 3'd3, PairAf = 3'd4, PairPc = 3'd5;

    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] regs_d [8];
    logic [DATA_W-1:0] wr_view [8];  // registers as seen after wr8/wr16 only
    logic [7:0]        wr_hit;       // bytes touched by wr8/wr16 this cycle
    logic [PW-1:0]     sp_q, sp_d, pc_q, pc_d, hl_step;

    logic [PW-1:0]     sh_mem_q [SHADOW_DEPTH];
    logic [PW-1:0]     sh_mem_d [SHADOW_DEPTH];
    logic [DepthW-1:0] depth_q, depth_d;
    logic              sh_err_q, sh_err_d, sh_full_q, sh_empty_q;
    logic              st_empty, st_full, pop_ok;
    logic [IdxW-1:0]   top_idx, push_idx;

    // Byte writes: wr8 first so that wr16 overrides it on a shared byte.
    always_comb begin
        wr_view = regs_q;
        wr_hit  = '0;
        if (wr8_en) begin
            wr_view[wr8_sel] = (wr8_sel == RegF) ? (wr8_data & FMask) : wr8_data;
            wr_hit[wr8_sel]  = 1'b1;
        end
        if (wr16_en) begin
            unique case (wr16_sel)
                PairBc: begin
                    {wr_view[RegB], wr_view[RegC]} = wr16_data;
                    wr_hit[RegB] = 1'b1;
                    wr_hit[RegC] = 1'b1;
                end
                PairDe: begin
                    {wr_view[RegD], wr_view[RegE]} = wr16_data;
                    wr_hit[RegD] = 1'b1;
                    wr_hit[RegE] = 1'b1;
                end
                PairHl: begin
                    {wr_view[RegH], wr_view[RegL]} = wr16_data;
                    wr_hit[RegH] = 1'b1;
                    wr_hit[RegL] = 1'b1;
                end
                PairAf: begin
                    wr_view[RegA] = wr16_data[PW-1:DATA_W];
                    wr_view[RegF] = wr16_data[DATA_W-1:0] & FMask;
                    wr_hit[RegA]  = 1'b1;
                    wr_hit[RegF]  = 1'b1;
                end
                default: ;  // SP/PC handled below; 6-7 ignored
            endcase
        end
    end

    // Shadow stack status and effective operations.
    always_comb begin
        st_empty = (depth_q == '0);
        st_full  = (depth_q == DepthMax);
        pop_ok   = sh_pop && !st_empty;
        top_idx  = IdxW'(depth_q - 1'b1);
        push_idx = IdxW'(depth_q);
    end

    // Register next state, lowest priority applied first.
    always_comb begin
        regs_d  = regs_q;
        sp_d    = sp_q;
        pc_d    = pc_q;
        hl_step = {regs_q[RegH], regs_q[RegL]};

        if (hl_inc && !hl_dec) hl_step = hl_step + PairOne;
        else if (hl_dec && !hl_inc) hl_step = hl_step - PairOne;
        regs_d[RegH] = hl_step[PW-1:DATA_W];
        regs_d[RegL] = hl_step[DATA_W-1:0];

        if (sp_inc && !sp_dec) sp_d = sp_q + PairOne;
        else if (sp_dec && !sp_inc) sp_d = sp_q - PairOne;

        if (pc_inc) pc_d = pc_q + PairOne;

        for (int i = 0; i < 4; i++) begin
            if (flag_we[i]) regs_d[RegF][DATA_W-4+i] = flag_in[i];
        end

        for (int i = 0; i < 8; i++) begin
            if (wr_hit[i]) regs_d[i] = wr_view[i];
        end

        if (wr16_en && wr16_sel == PairSp) sp_d = wr16_data;
        if (wr16_en && wr16_sel == PairPc) pc_d = wr16_data;

        if (pop_ok) pc_d = sh_mem_q[top_idx];
    end

    // Shadow stack next state.
    always_comb begin
        sh_mem_d = sh_mem_q;
        depth_d  = depth_q;
        sh_err_d = sh_err_q;
        if (sh_push && sh_pop && !st_empty) begin
            // swap: pop returns the old top, the current PC replaces it
            sh_mem_d[top_idx] = pc_q;
        end else if (sh_push) begin
            if (st_full) begin
                sh_err_d = 1'b1;
            end else begin
                sh_mem_d[push_idx] = pc_q;
                depth_d            = depth_q + 1'b1;
            end
        end else if (sh_pop) begin
            if (st_empty) sh_err_d = 1'b1;
            else depth_d = depth_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
            for (int i = 0; i < int'(SHADOW_DEPTH); i++) sh_mem_q[i] <= '0;
            sp_q       <= SP_RESET;
            pc_q       <= PC_RESET;
            depth_q    <= '0;
            sh_err_q   <= 1'b0;
            sh_full_q  <= 1'b0;
            sh_empty_q <= 1'b1;
        end else begin
            regs_q     <= regs_d;
            sh_mem_q   <= sh_mem_d;
            sp_q       <= sp_d;
            pc_q       <= pc_d;
            depth_q    <= depth_d;
            sh_err_q   <= sh_err_d;
            sh_full_q  <= (depth_d == DepthMax);
            sh_empty_q <= (depth_d == '0);
        end
    end

    for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
        logic [2:0] sel;
        assign sel = rd_sel[p*3 +: 3];
        assign rd_data[p*DATA_W +: DATA_W] = BYPASS ? wr_view[sel] : regs_q[sel];
    end

    assign pc       = pc_q;
    assign sp       = sp_q;
    assign hl       = {regs_q[RegH], regs_q[RegL]};
    assign flags    = regs_q[RegF][DATA_W-1 -: 4];
    assign sh_full  = sh_full_q;
    assign sh_empty = sh_empty_q;
    assign sh_err   = sh_err_q;

endmodule

// File: doc/sm83_regfile.md
# sm83_regfile

Parametrised SM83 architectural register file: A, F, B, C, D, E, H, L, SP and PC with 8-bit and 16-bit pair access, per-flag masked flag writes and pointer increment/decrement. It adds an interrupt shadow stack for PC. It sits between the decoder/sequencer and the ALU. It replaces ad-hoc register storage with one block that owns every architectural-state update rule.

## Interface
- DATA_W, 8, byte width; pairs are 2*DATA_W.
- NUM_RD, 2, number of independent 8-bit read ports.
- BYPASS, 0, 1 = read ports return same-cycle wr8/wr16 data.
- SHADOW_DEPTH, 2, PC shadow stack entries (≥1).
- PC_RESET, 0, PC value after reset.
- SP_RESET, 16'hFFFE (2*DATA_W wide), SP value after reset.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_sel  in  NUM_RD×3  8-bit register index per port: 0 B, 1 C, 2 D, 3 E, 4 H, 5 L, 6 A, 7 F.
- rd_data  out  NUM_RD×DATA_W  selected register value.
- wr8_en / wr8_sel / wr8_data  in  1 / 3 / DATA_W  8-bit write.
- wr16_en / wr16_sel / wr16_data  in  1 / 3 / 2*DATA_W  pair write: 0 BC, 1 DE, 2 HL, 3 SP, 4 AF, 5 PC; 6–7 ignored.
- flag_we / flag_in  in  4 / 4  per-flag write {Z,N,H,C}.
- pc_inc, sp_inc, sp_dec, hl_inc, hl_dec  in  1 each  pointer step by 1.
- sh_push, sh_pop  in  1 each  shadow stack push current PC / pop into PC.
- pc, sp, hl  out  2*DATA_W each  current registered values.
- flags  out  4  {Z,N,H,C} of F.
- sh_full, sh_empty  out  1 each  stack status.
- sh_err  out  1  sticky overflow/underflow; cleared only by rst.

## Operation
- Reset: all 8-bit registers 0, SP=SP_RESET, PC=PC_RESET, stack empty (sh_empty=1, sh_full=0), sh_err=0.
- F low 4 bits always read 0 and are never stored. Writes to F via wr8 or AF keep only the top 4 bits.
- Per-target priority, highest first:
  - sh_pop, PC only.
  - wr16.
  - wr8.
  - flag_we (F bits only).
  - inc/dec.
- wr16 and wr8 hitting the same byte: wr16 wins for that byte. The other byte of the pair still takes wr16 data.
- flag_we bit set with no higher-priority F write: that flag bit takes flag_in. Unmasked flag bits hold.
- sp_inc and sp_dec together: SP unchanged. The same rule applies to hl_inc with hl_dec.
- Inc/dec wrap modulo 2^(2*DATA_W): 0xFFFF+1 gives 0x0000; 0x0000−1 gives 0xFFFF.
- Inc/dec operate on H:L as one pair, so L carries into H.
- Shadow stack is a LIFO of PC values with depth counter 0..SHADOW_DEPTH.
  - push: top ← current PC (pre-update value). A PC update in the same cycle still applies.
  - pop: PC ← top, depth−1.
  - push when full: ignored, sh_err←1.
  - pop when empty: ignored, sh_err←1.
  - push+pop same cycle, non-empty: PC ← old top, top ← current PC, depth unchanged.
  - push+pop same cycle, empty: acts as push only; no error.
- BYPASS=1: rd_data reflects a same-cycle wr16/wr8 to the selected byte, using the same priority. It never reflects flag_we or inc/dec. BYPASS=0: rd_data is purely registered state.

## Timing
- rd_data is combinational from state (plus write ports if BYPASS=1). No clocked read latency.
- All writes, steps and stack operations are visible on pc/sp/hl/flags/rd_data one cycle after the edge that samples them.
- rst has priority over every input. Asserting it mid-operation discards all same-cycle writes and stack operations.
- sh_full and sh_empty are registered and derived from the depth counter.

## Test plan
- Reset, then read all 8 indices → all 0; pc=PC_RESET, sp=0xFFFE, sh_empty=1.
- wr16 AF=0x12FF, then read F → 0xF0, flags=4'hF. Next cycle flag_we=4'b0001, flag_in=0 → F=0xE0.
- HL=0x00FF, hl_inc → HL=0x0100. SP=0x0000, sp_dec → 0xFFFF. sp_inc+sp_dec together → SP unchanged.
- Same cycle: wr16 HL=0xABCD, wr8 L=0x11, hl_inc → HL=0xABCD next cycle. With BYPASS=1, rd_sel=L returns 0xCD in that cycle.
- SHADOW_DEPTH=2, PC=0x0150:
  - push, set PC=0x0040, push → sh_full=1.
  - third push → sh_err=1, depth still 2.
  - pop → PC=0x0040; pop → PC=0x0150; pop → sh_err stays 1.
- pc_inc with sh_pop, top=0x2000 → PC=0x2000. Then rst asserted with wr8 B=0x55 → B=0, stack empty.
